// File: rtl/ic1337_pkg.sv
// ic1337 vector driver: shared types and constants.
// Holds the FSM state enum, the vector field layout, the golden table and the "no failure" marker.
// The optional stop-on-first-failure build is selected by IC1337_DRV_STOP_ON_FAIL_EN in the top module.
package ic1337_pkg;

  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;

  // Vector layout, MSB first: {I2, I1, I0, expQ0, expQ1, expZ}
  localparam int VEC_W      = 6;
  localparam int OFF_EXP_Z  = 0;
  localparam int OFF_EXP_Q1 = 1;
  localparam int OFF_EXP_Q0 = 2;
  localparam int OFF_I0     = 3;
  localparam int OFF_I1     = 4;
  localparam int OFF_I2     = 5;

  localparam int GOLDEN_DEPTH = 16;
  localparam int ROM_ADDR_W   = 4;

  // Reference response: Q0 <= I0^I2, Q1 <= I1|I2 (registered), Z = Q0&Q1.
  // Entries 0..7 walk the inputs upward, entries 8..15 walk them back down.
  localparam logic [VEC_W-1:0] GOLDEN [GOLDEN_DEPTH] = '{
    6'h00, 6'h0C, 6'h12, 6'h1F, 6'h27, 6'h2A, 6'h37, 6'h3A,
    6'h3A, 6'h37, 6'h2A, 6'h27, 6'h1F, 6'h12, 6'h0C, 6'h00
  };

  localparam logic [7:0] FAIL_NONE = 8'hFF;

endpackage

// File: rtl/ic1337_vector_rom.sv
// Golden vector lookup for the ic1337 driver.
// Latency: combinational, no registers.
// Backpressure: none; the table repeats every 16 entries when more vectors are requested.
import ic1337_pkg::*;

module ic1337_vector_rom (
  input  logic [ROM_ADDR_W-1:0] addr,
  output logic [VEC_W-1:0]      vec
);

  // Plain table read
  always_comb begin
    vec = GOLDEN[addr];
  end

endmodule

// File: rtl/ic1337_vector_driver.sv
// On-board stimulus/response checker for ic1337: applies table vectors, compares Q0/Q1/Z, reports result.
// Latency: 2+SETTLE_CYCLES cycles per vector; done rises NUM_VECTORS*(2+SETTLE_CYCLES) cycles after start.
// Backpressure: start is ignored while busy; define IC1337_DRV_STOP_ON_FAIL_EN to end the run at the first mismatch.
import ic1337_pkg::*;

module ic1337_vector_driver #(
  parameter int NUM_VECTORS   = 16,
  parameter int CNT_W         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             I0,
  output logic             I1,
  output logic             I2,
  input  logic             Q0,
  input  logic             Q1,
  input  logic             Z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       fail_index
);

  localparam int WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_INDEX = 8'(NUM_VECTORS - 1);

  state_t           state, state_nxt;
  logic [VEC_W-1:0] vec_q, vec_nxt;
  logic [7:0]       index, index_nxt, index_p1;
  logic [CNT_W-1:0] err_nxt;
  logic [7:0]       fidx_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [VEC_W-1:0] rom_vec;
  logic             mismatch;
  logic             last;

  // The whole vector is latched on entry to APPLY so the expected bits stay
  // aligned with the stimulus; the ROM is only ever asked for the next entry.
  assign index_p1 = index + 8'd1;
  assign rom_addr = (state == CHECK) ? index_p1[ROM_ADDR_W-1:0] : '0;

  ic1337_vector_rom u_rom (
    .addr (rom_addr),
    .vec  (rom_vec)
  );

  assign I0 = vec_q[OFF_I0];
  assign I1 = vec_q[OFF_I1];
  assign I2 = vec_q[OFF_I2];

  assign mismatch = ({Q0, Q1, Z} !=
                     {vec_q[OFF_EXP_Q0], vec_q[OFF_EXP_Q1], vec_q[OFF_EXP_Z]});
  assign last     = (index == LAST_INDEX);

  assign busy = (state == APPLY) || (state == WAIT) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = (state == DONE) && (err_count == '0);

  // Next-state and datapath updates for the run sequencer
  always_comb begin
    state_nxt = state;
    vec_nxt   = vec_q;
    index_nxt = index;
    err_nxt   = err_count;
    fidx_nxt  = fail_index;
    wait_nxt  = wait_cnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = APPLY;
          vec_nxt   = rom_vec;
          index_nxt = '0;
          err_nxt   = '0;
          fidx_nxt  = FAIL_NONE;
        end
      end
      APPLY: begin
        state_nxt = WAIT;
        wait_nxt  = WAIT_LOAD;
      end
      WAIT: begin
        if (wait_cnt == '0) state_nxt = CHECK;
        else                wait_nxt  = wait_cnt - WAIT_W'(1);
      end
      CHECK: begin
        if (mismatch) begin
          if (err_count != '1)        err_nxt  = err_count + CNT_W'(1);
          if (fail_index == FAIL_NONE) fidx_nxt = index;
        end
`ifdef IC1337_DRV_STOP_ON_FAIL_EN
        if (mismatch || last) begin
`else
        if (last) begin
`endif
          state_nxt = DONE;
        end else begin
          state_nxt = APPLY;
          index_nxt = index_p1;
          vec_nxt   = rom_vec;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and result registers; reset discards any partial run
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec_q      <= '0;
      index      <= '0;
      err_count  <= '0;
      fail_index <= FAIL_NONE;
      wait_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      vec_q      <= vec_nxt;
      index      <= index_nxt;
      err_count  <= err_nxt;
      fail_index <= fidx_nxt;
      wait_cnt   <= wait_nxt;
    end
  end

endmodule

// File: tb/tb_ic1337_vector_driver.sv
// Directed bench for ic1337_vector_driver with a behavioural ic1337 beside it.
// Main instance runs golden, stuck-Z, re-start, abort and rst/start-collision steps; a CNT_W=2 instance sees inverted responses.
// Expectations follow IC1337_DRV_STOP_ON_FAIL_EN when it is defined.
module tb_ic1337_vector_driver;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic fault_z;

  logic i0, i1, i2, q0, q1, z;
  logic busy, done, pass;
  logic [7:0] err_count, fail_index;

  logic s_i0, s_i1, s_i2, s_q0, s_q1, s_z;
  logic s_busy, s_done, s_pass;
  logic [1:0] s_err_count;
  logic [7:0] s_fail_index;

  logic m_q0, m_q1, sm_q0, sm_q1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Behavioural ic1337: Q0 <= I0^I2, Q1 <= I1|I2, Z = Q0&Q1
  always_ff @(posedge clk) begin
    m_q0  <= i0 ^ i2;
    m_q1  <= i1 | i2;
    sm_q0 <= s_i0 ^ s_i2;
    sm_q1 <= s_i1 | s_i2;
  end
  assign q0   = m_q0;
  assign q1   = m_q1;
  assign z    = fault_z ? 1'b0 : (m_q0 & m_q1);
  assign s_q0 = ~sm_q0;
  assign s_q1 = ~sm_q1;
  assign s_z  = ~(sm_q0 & sm_q1);

  ic1337_vector_driver #(.NUM_VECTORS(16), .CNT_W(8), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .I0(i0), .I1(i1), .I2(i2), .Q0(q0), .Q1(q1), .Z(z),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_index(fail_index)
  );

  ic1337_vector_driver #(.NUM_VECTORS(16), .CNT_W(2), .SETTLE_CYCLES(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start),
    .I0(s_i0), .I1(s_i1), .I2(s_i2), .Q0(s_q0), .Q1(s_q1), .Z(s_z),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err_count), .fail_index(s_fail_index)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse start across one edge; returns at the negedge after the sampling edge
  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_stim"}, {29'd0, i2, i1, i0}, 32'd0);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_done"}, done, 1'b0);
    check({pfx, "_pass"}, pass, 1'b0);
    check({pfx, "_err"},  err_count, 8'd0);
    check({pfx, "_fidx"}, fail_index, 8'hFF);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fault_z = 1'b0;

    // Reset held for two edges
    @(negedge clk);
    step(); step();
    check_reset_vals("rst");
    rst = 1'b0;
    step();

    // Golden run with a start re-pulse while busy
    start_run();
    check("gold_busy_c0", busy, 1'b1);
    check("gold_stim_v0", {29'd0, i2, i1, i0}, 32'd0);
    for (int c = 1; c <= 48; c++) begin
      step();
      if (c == 3)  check("gold_stim_v1", {29'd0, i2, i1, i0}, 32'd1);
      if (c == 9)  check("gold_stim_v3", {29'd0, i2, i1, i0}, 32'd3);
      if (c == 19) start = 1'b1;
      if (c == 20) start = 1'b0;
      if (c == 47) check("gold_done_c47", done, 1'b0);
`ifdef IC1337_DRV_STOP_ON_FAIL_EN
      if (c == 3) begin
        check("sat_stop_done", s_done, 1'b1);
        check("sat_stop_err", s_err_count, 2'd1);
        check("sat_stop_fidx", s_fail_index, 8'd0);
      end
`endif
    end
    check("gold_done_c48", done, 1'b1);
    check("gold_busy_c48", busy, 1'b0);
    check("gold_pass", pass, 1'b1);
    check("gold_err", err_count, 8'd0);
    check("gold_fidx", fail_index, 8'hFF);
    check("sat_done", s_done, 1'b1);
    check("sat_pass", s_pass, 1'b0);
    check("sat_fidx", s_fail_index, 8'd0);
`ifdef IC1337_DRV_STOP_ON_FAIL_EN
    check("sat_err", s_err_count, 2'd1);
`else
    check("sat_err", s_err_count, 2'd3);
`endif
    step(); step(); step();
    check("gold_done_hold", done, 1'b1);

    // Z stuck at 0: entries 3,4,6,9,11,12 expect Z=1
    fault_z = 1'b1;
    start_run();
    check("stz_restart_busy", busy, 1'b1);
    check("stz_restart_err", err_count, 8'd0);
`ifdef IC1337_DRV_STOP_ON_FAIL_EN
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 11) check("stz_done_c11", done, 1'b0);
    end
    check("stz_done_c12", done, 1'b1);
    check("stz_err", err_count, 8'd1);
    check("stz_fidx", fail_index, 8'd3);
    check("stz_pass", pass, 1'b0);
`else
    for (int c = 1; c <= 48; c++) begin
      step();
      if (c == 11) check("stz_err_c11", err_count, 8'd0);
      if (c == 12) check("stz_err_c12", err_count, 8'd1);
      if (c == 12) check("stz_fidx_c12", fail_index, 8'd3);
      if (c == 47) check("stz_done_c47", done, 1'b0);
    end
    check("stz_done", done, 1'b1);
    check("stz_err", err_count, 8'd6);
    check("stz_fidx", fail_index, 8'd3);
    check("stz_pass", pass, 1'b0);
`endif

    // Abort at cycle 20 of a faulty run, then a clean run
    start_run();
    for (int c = 1; c <= 20; c++) step();
    rst = 1'b1;
    step();
    check_reset_vals("abort");
    rst = 1'b0;
    fault_z = 1'b0;
    step();
    start_run();
    for (int c = 1; c <= 48; c++) begin
      step();
      if (c == 47) check("rerun_done_c47", done, 1'b0);
    end
    check("rerun_done", done, 1'b1);
    check("rerun_pass", pass, 1'b1);
    check("rerun_fidx", fail_index, 8'hFF);

    // rst and start together: rst wins
    rst = 1'b1;
    start_run();
    check("collide_busy", busy, 1'b0);
    check("collide_done", done, 1'b0);
    rst = 1'b0;
    step();
    check("collide_idle_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ic1337_vector_driver.md
Name: ic1337_vector_driver

Overview:
Synthesizable stimulus/response engine for the ic1337 sequential circuit: drives I0/I1/I2 from an internal vector table and checks returned Q0/Q1/Z against expected values. Provides in hardware what the bench does in simulation, for on-board self-test.
- Sits beside ic1337, with ports wired directly to the circuit's inputs and outputs.
- Reports pass/fail, error count and first failing vector index.

Parameters:
NUM_VECTORS, 16, number of table entries applied per run (1..256)
CNT_W, 8, width of err_count; counter saturates
SETTLE_CYCLES, 1, cycles waited after each apply before checking (min 1; 0 illegal)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
start  input  1  level-sampled run request; honoured only in IDLE or DONE
I0  output  1  stimulus to ic1337 I0
I1  output  1  stimulus to ic1337 I1
I2  output  1  stimulus to ic1337 I2
Q0  input  1  response from ic1337 Q0
Q1  input  1  response from ic1337 Q1
Z  input  1  response from ic1337 Z
busy  output  1  high while a run is in progress (APPLY/WAIT/CHECK)
done  output  1  high in DONE; held until next start or rst
pass  output  1  valid when done=1; 1 iff err_count==0
err_count  output  CNT_W  mismatched vectors in current/last run
fail_index  output  8  index of first mismatch; 8'hFF if none

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; I0=I1=I2=0; busy=0; done=0; pass=0; err_count=0; fail_index=8'hFF; index=0; wait counter=0.
- Vector format, 6 bits: {I2,I1,I0,expQ0,expQ1,expZ}.
- IDLE:
  - start=1 -> APPLY; index=0; err_count=0; fail_index=FF; busy=1.
- APPLY (1 cycle):
  - I2..I0 registered from table[index] on the edge entering APPLY.
  - ic1337 captures them on the edge leaving APPLY.
  - Next state WAIT, counter loaded with SETTLE_CYCLES-1.
- WAIT: count down; at 0 -> CHECK.
- CHECK (1 cycle): compare {Q0,Q1,Z} with {expQ0,expQ1,expZ}. On mismatch:
  - err_count increments, saturating at all ones.
  - fail_index is written only if it is still FF.
  - Then: if index==NUM_VECTORS-1 -> DONE; else index++ and -> APPLY.
- Stimulus holds its value through WAIT and CHECK; it changes only on entry to APPLY.
- Per-vector latency: 2+SETTLE_CYCLES cycles. done rises exactly NUM_VECTORS*(2+SETTLE_CYCLES) cycles after the edge that sampled start.
- DONE: busy=0, done=1; pass=(err_count==0); I0..I2 hold the last vector. start=1 -> APPLY, with the same actions as from IDLE.
- start is ignored while busy=1.
- rst mid-run aborts immediately to reset values. No partial results are retained.
- Simultaneous rst and start: rst wins.
- Counter saturation: err_count never wraps. fail_index stays at the first failure.

Optional Feature:
IC1337_DRV_STOP_ON_FAIL_EN
- Defined: the first mismatch in CHECK goes directly to DONE. err_count=1, fail_index=that index, pass=0; remaining vectors are skipped.
- Undefined: all NUM_VECTORS vectors are always applied.

Decomposition:
- Package ic1337_pkg holds:
  - state enum {IDLE, APPLY, WAIT, CHECK, DONE};
  - VEC_W=6 and field-offset constants;
  - the default 16-entry golden vector constant array;
  - FAIL_NONE=8'hFF.
- One sub-module, ic1337_vector_rom: combinational lookup indexed by index, returning the 6-bit vector.

Test Plan:
- Reset values: assert rst for 2 cycles, then check I0..I2=0, busy=0, done=0, err_count=0, fail_index=FF.
- Golden pass: correct ic1337, start pulse, NUM_VECTORS=16, SETTLE=1. Expect done exactly 48 cycles later, pass=1, err_count=0, fail_index=FF.
- Stuck-at fault: behavioural ic1337 with Z forced 0. Expect err_count = number of table entries with expZ=1, and fail_index = first such index.
- Saturation: CNT_W=2, all outputs inverted. Expect err_count=3 (not wrap), fail_index=0.
- Abort and ignore:
  - start re-pulsed while busy -> no effect on progress.
  - rst asserted at cycle 20 of a run -> reset values next cycle; a new start then runs to completion normally.
- Stop-on-fail (macro defined), with Z fault: done asserts right after the first failing CHECK, err_count=1.
